// File: rtl/coupled_pkg.sv
// Shared helpers for the clocked coupled cell.
//
// Purpose:
//   - Sizing of the free-running timestamp counter.
//   - One-hot weight helpers used by the top-level delay calculation.
//
// Contents:
//   MAX_WEIGHTS   widest weight vector the helpers accept
//   ts_width()    timestamp counter width for a given parameter set
//   is_onehot()   1 when exactly one bit of the vector is set
//   onehot_to_idx() index of the set bit of a one-hot vector
package coupled_pkg;

  localparam int MAX_WEIGHTS = 32;

  // Due times never lie more than the largest delay ahead of the counter,
  // so one extra bit beyond that span lets a signed difference order them.
  function automatic int ts_width(input int base_delay, input int s_extra,
                                  input int num_weights);
    return $clog2(base_delay + s_extra + num_weights) + 1;
  endfunction

  function automatic logic is_onehot(input logic [MAX_WEIGHTS-1:0] v);
    return (v != '0) && ((v & (v - MAX_WEIGHTS'(1))) == '0);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_WEIGHTS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WEIGHTS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/clocked_coupled_cell_edge_delay_queue.sv
// One delay path of the coupled cell.
//
// Purpose:
//   Detects edges on in_bit, schedules each one for a due timestamp that is
//   delay cycles ahead (never earlier than one cycle after the previously
//   scheduled edge), and toggles out_bit when the oldest pending edge falls
//   due. Edges arriving with the queue full and no pop in the same cycle are
//   dropped and flagged.
//
// Ports:
//   clk       cell clock
//   rstn      asynchronous active-low reset
//   in_bit    oscillator phase to be delayed
//   ts        shared free-running timestamp
//   delay     delay in cycles for an edge detected this cycle (>= 1)
//   out_bit   delayed phase
//   overflow  sticky: an edge was dropped
module edge_delay_queue
  import coupled_pkg::*;
#(
  parameter int TS_W       = 4,
  parameter int EDGE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_bit,
  input  logic [TS_W-1:0] ts,
  input  logic [TS_W-1:0] delay,
  output logic            out_bit,
  output logic            overflow
);

  localparam int PTR_W = (EDGE_DEPTH > 1) ? $clog2(EDGE_DEPTH) : 1;
  localparam int CNT_W = $clog2(EDGE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(EDGE_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(EDGE_DEPTH);

  logic             in_q, in_d;
  logic             out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TS_W-1:0]  last_due_q, last_due_d;
  logic [TS_W-1:0]  due_mem_q [EDGE_DEPTH];

  logic            edge_seen;
  logic            pop;
  logic            push;
  logic            full;
  logic [TS_W-1:0] cand_due;
  logic [TS_W-1:0] chained_due;
  logic [TS_W-1:0] due_diff;
  logic [TS_W-1:0] due_new;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    edge_seen   = in_bit ^ in_q;
    full        = (count_q == FULL_CNT);
    pop         = (count_q != '0) && (due_mem_q[head_q] == ts);
    cand_due    = ts + delay;
    chained_due = last_due_q + TS_W'(1);
    // Both candidates lie within one delay span of ts, so the sign of the
    // wrapped difference tells which one is later.
    due_diff    = chained_due - cand_due;
    due_new     = cand_due;
    if ((count_q != '0) && !due_diff[TS_W-1]) begin
      due_new = chained_due;
    end

    // A pop in the same cycle frees the slot the new edge needs.
    push = edge_seen && (!full || pop);

    in_d       = in_bit;
    out_d      = out_q ^ pop;
    ovf_d      = ovf_q | (edge_seen & full & ~pop);
    head_d     = pop  ? next_ptr(head_q) : head_q;
    tail_d     = push ? next_ptr(tail_q) : tail_q;
    last_due_d = push ? due_new : last_due_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_q       <= 1'b0;
      out_q      <= 1'b0;
      ovf_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      last_due_q <= '0;
    end else begin
      in_q       <= in_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      last_due_q <= last_due_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      due_mem_q[tail_q] <= due_new;
    end
  end

  assign out_bit  = out_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/clocked_coupled_cell.sv
// Clocked coupled oscillator cell.
//
// Purpose:
//   Re-emits each edge of the source (sin) and destination (din) phases on
//   sout / dout after a delay set by a one-hot weight and by whether the
//   incoming phase disagrees with the opposite path's delayed output.
//   A mismatch uses delay BASE + k, a match BASE + (NUM_WEIGHTS-1-k), where
//   k is the set weight bit; the s path adds S_EXTRA to BASE.
//
// Ports:
//   clk           cell clock
//   rstn          asynchronous active-low reset
//   sin, din      source / destination phases, synchronous to clk
//   sout, dout    delayed source / destination phases
//   weight_in     new one-hot weight
//   weight_valid  weight_in valid
//   weight_ready  cell accepts a weight (high from the first clk after reset)
//   weight_err    one-cycle pulse: a non-one-hot weight was rejected
//   s_overflow    sticky: an s-path edge was dropped
//   d_overflow    sticky: a d-path edge was dropped
module clocked_coupled_cell
  import coupled_pkg::*;
#(
  parameter int NUM_WEIGHTS = 5,
  parameter int BASE_DELAY  = 2,
  parameter int S_EXTRA     = 1,
  parameter int EDGE_DEPTH  = 4,
  parameter logic [NUM_WEIGHTS-1:0] WEIGHT_RESET = NUM_WEIGHTS'(1) << (NUM_WEIGHTS / 2)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sin,
  input  logic                   din,
  output logic                   sout,
  output logic                   dout,
  input  logic [NUM_WEIGHTS-1:0] weight_in,
  input  logic                   weight_valid,
  output logic                   weight_ready,
  output logic                   weight_err,
  output logic                   s_overflow,
  output logic                   d_overflow
);

  localparam int TS_W   = ts_width(BASE_DELAY, S_EXTRA, NUM_WEIGHTS);
  localparam int BASE_S = BASE_DELAY + S_EXTRA;
  localparam int BASE_D = BASE_DELAY;

  logic [NUM_WEIGHTS-1:0] weight_q, weight_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic [TS_W-1:0]        ts_q, ts_d;

  logic            transfer;
  logic            weight_ok;
  logic            mismatch_s;
  logic            mismatch_d;
  int              k;
  logic [TS_W-1:0] delay_s;
  logic [TS_W-1:0] delay_d;
  logic            sout_bit;
  logic            dout_bit;

  always_comb begin
    transfer  = weight_valid & ready_q;
    weight_ok = is_onehot(MAX_WEIGHTS'(weight_in));
    weight_d  = (transfer && weight_ok) ? weight_in : weight_q;
    err_d     = transfer & ~weight_ok;
    ready_d   = 1'b1;
    ts_d      = ts_q + TS_W'(1);
  end

  // Delay uses the weight held before this clk, so a weight accepted now
  // only affects edges sampled afterwards.
  always_comb begin
    k          = onehot_to_idx(MAX_WEIGHTS'(weight_q));
    mismatch_s = sin ^ dout_bit;
    mismatch_d = din ^ sout_bit;
    delay_s    = TS_W'(BASE_S + (mismatch_s ? k : NUM_WEIGHTS - 1 - k));
    delay_d    = TS_W'(BASE_D + (mismatch_d ? k : NUM_WEIGHTS - 1 - k));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      weight_q <= WEIGHT_RESET;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ts_q     <= '0;
    end else begin
      weight_q <= weight_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      ts_q     <= ts_d;
    end
  end

  edge_delay_queue #(
    .TS_W       (TS_W),
    .EDGE_DEPTH (EDGE_DEPTH)
  ) u_s_path (
    .clk      (clk),
    .rstn     (rstn),
    .in_bit   (sin),
    .ts       (ts_q),
    .delay    (delay_s),
    .out_bit  (sout_bit),
    .overflow (s_overflow)
  );

  edge_delay_queue #(
    .TS_W       (TS_W),
    .EDGE_DEPTH (EDGE_DEPTH)
  ) u_d_path (
    .clk      (clk),
    .rstn     (rstn),
    .in_bit   (din),
    .ts       (ts_q),
    .delay    (delay_d),
    .out_bit  (dout_bit),
    .overflow (d_overflow)
  );

  assign sout         = sout_bit;
  assign dout         = dout_bit;
  assign weight_ready = ready_q;
  assign weight_err   = err_q;

endmodule

// File: tb/tb_clocked_coupled_cell.sv
`timescale 1ns/1ps
module tb_clocked_coupled_cell;

  localparam int NW    = 5;
  localparam int BASE  = 2;
  localparam int SX    = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sin = 1'b0;
  logic          din = 1'b0;
  logic          weight_valid = 1'b0;
  logic [NW-1:0] weight_in = '0;
  logic          sout, dout, weight_ready, weight_err, s_overflow, d_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  clocked_coupled_cell #(
    .NUM_WEIGHTS (NW),
    .BASE_DELAY  (BASE),
    .S_EXTRA     (SX),
    .EDGE_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sin          (sin),
    .din          (din),
    .sout         (sout),
    .dout         (dout),
    .weight_in    (weight_in),
    .weight_valid (weight_valid),
    .weight_ready (weight_ready),
    .weight_err   (weight_err),
    .s_overflow   (s_overflow),
    .d_overflow   (d_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Pending edges are kept as absolute cycle numbers, so no wrap handling.
  int            mc = 0;
  logic          m_sin_prev = 1'b0, m_din_prev = 1'b0;
  logic          m_sout = 1'b0, m_dout = 1'b0;
  logic          m_ready = 1'b0, m_err = 1'b0;
  logic          m_sovf = 1'b0, m_dovf = 1'b0;
  logic [NW-1:0] m_weight = NW'(1) << (NW / 2);
  int            sq[$];
  int            dq[$];
  int            s_last = 0, d_last = 0;
  logic          m_mis_s, m_mis_d, m_tog_s, m_tog_d;
  int            m_k, m_ds, m_dd, m_due;

  function automatic int weight_index(input logic [NW-1:0] w);
    int r;
    r = 0;
    for (int i = 0; i < NW; i++) if (w[i]) r = i;
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mc = 0; m_sin_prev = 0; m_din_prev = 0; m_sout = 0; m_dout = 0;
      m_ready = 0; m_err = 0; m_sovf = 0; m_dovf = 0;
      m_weight = NW'(1) << (NW / 2);
      sq.delete(); dq.delete(); s_last = 0; d_last = 0;
    end else begin
      mc++;
      m_mis_s = sin ^ m_dout;
      m_mis_d = din ^ m_sout;
      m_k  = weight_index(m_weight);
      m_ds = BASE + SX + (m_mis_s ? m_k : NW - 1 - m_k);
      m_dd = BASE + (m_mis_d ? m_k : NW - 1 - m_k);
      m_tog_s = (sq.size() > 0) && (sq[0] == mc);
      m_tog_d = (dq.size() > 0) && (dq[0] == mc);
      if (m_tog_s) void'(sq.pop_front());
      if (m_tog_d) void'(dq.pop_front());
      if (sin != m_sin_prev) begin
        m_due = (mc + m_ds > s_last + 1) ? mc + m_ds : s_last + 1;
        if (sq.size() < DEPTH) begin sq.push_back(m_due); s_last = m_due; end
        else m_sovf = 1;
      end
      if (din != m_din_prev) begin
        m_due = (mc + m_dd > d_last + 1) ? mc + m_dd : d_last + 1;
        if (dq.size() < DEPTH) begin dq.push_back(m_due); d_last = m_due; end
        else m_dovf = 1;
      end
      if (m_tog_s) m_sout = ~m_sout;
      if (m_tog_d) m_dout = ~m_dout;
      m_sin_prev = sin;
      m_din_prev = din;
      m_err = weight_valid && m_ready && ($countones(weight_in) != 1);
      if (weight_valid && m_ready && ($countones(weight_in) == 1)) m_weight = weight_in;
      m_ready = 1;
    end
  end

  // Compare against the model on every cycle.
  always @(posedge clk) begin
    #1;
    check("sout_vs_model", sout, m_sout);
    check("dout_vs_model", dout, m_dout);
    check("ready_vs_model", weight_ready, m_ready);
    check("err_vs_model", weight_err, m_err);
    check("sovf_vs_model", s_overflow, m_sovf);
    check("dovf_vs_model", d_overflow, m_dovf);
  end

  // Toggle log: cycle number of every output change, for literal latency checks.
  int   cyc = 0;
  int   s_tog[$];
  int   d_tog[$];
  logic s_prev = 1'b0, d_prev = 1'b0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (sout !== s_prev) s_tog.push_back(cyc);
    if (dout !== d_prev) d_tog.push_back(cyc);
    s_prev = sout;
    d_prev = dout;
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rstn = 0; sin = 0; din = 0; weight_valid = 0;
    repeat (3) @(negedge clk);
    rstn = 1;
  endtask

  task automatic set_weight(input logic [NW-1:0] w);
    @(negedge clk);
    weight_in = w; weight_valid = 1;
    @(negedge clk);
    weight_valid = 0;
  endtask

  task automatic edge_lat(input bit on_s, input logic v, input int exp, input string name);
    int n0, t;
    @(negedge clk);
    s_tog.delete(); d_tog.delete();
    n0 = cyc + 1;
    if (on_s) sin = v; else din = v;
    repeat (12) @(negedge clk);
    t = -1;
    if (on_s && s_tog.size() == 1) t = s_tog[0] - n0;
    if (!on_s && d_tog.size() == 1) t = d_tog[0] - n0;
    check(name, t, exp);
    check({name, "_other_path_quiet"}, on_s ? d_tog.size() : s_tog.size(), 0);
  endtask

  int n0;
  int p;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sout", sout, 0);
    check("rst_dout", dout, 0);
    check("rst_ready", weight_ready, 0);
    check("rst_sovf", s_overflow, 0);
    rstn = 1;
    #1 check("ready_before_first_clk", weight_ready, 0);
    @(posedge clk); #1;
    check("ready_after_first_clk", weight_ready, 1);
    check("err_after_reset", weight_err, 0);

    // Weight 00001: s mismatch 3, s match 7, d mismatch 2
    set_weight(5'b00001);
    edge_lat(1'b1, 1'b1, 3, "s_mismatch_lat");
    check("s_mismatch_level", sout, 1);
    edge_lat(1'b1, 1'b0, 7, "s_match_lat");
    edge_lat(1'b0, 1'b1, 2, "d_mismatch_lat");
    check("d_rise_level", dout, 1);

    // Ordering: D=7 edge then D=3 edge must toggle at N+7 and N+8
    @(negedge clk);
    s_tog.delete(); n0 = cyc + 1; sin = 1;
    @(negedge clk); sin = 0;
    repeat (12) @(negedge clk);
    check("order_count", s_tog.size(), 2);
    if (s_tog.size() == 2) begin
      check("order_first", s_tog[0] - n0, 7);
      check("order_second", s_tog[1] - n0, 8);
    end

    // Overflow: five back-to-back edges into a 4-deep queue
    check("ovf_before", s_overflow, 0);
    @(negedge clk);
    s_tog.delete(); n0 = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      sin = ~sin;
      @(negedge clk);
    end
    check("ovf_set", s_overflow, 1);
    repeat (12) @(negedge clk);
    check("ovf_toggle_count", s_tog.size(), 4);
    if (s_tog.size() == 4) begin
      check("ovf_first_toggle", s_tog[0] - n0, 7);
      check("ovf_last_toggle", s_tog[3] - n0, 10);
    end
    check("ovf_sticky", s_overflow, 1);
    check("d_ovf_untouched", d_overflow, 0);

    // Weight error leaves the reset weight 00100 in place
    do_reset();
    check("ovf_cleared_by_reset", s_overflow, 0);
    set_weight(5'b00110);
    check("werr_pulse", weight_err, 1);
    @(negedge clk);
    check("werr_one_cycle", weight_err, 0);
    edge_lat(1'b1, 1'b1, 5, "s_lat_after_bad_weight");

    // Reset with two pending edges: nothing may toggle afterwards
    @(negedge clk); sin = 0;
    @(negedge clk); sin = 1;
    @(negedge clk);
    rstn = 0; sin = 0; din = 0;
    #1 check("async_rst_sout", sout, 0);
    repeat (3) @(negedge clk);
    rstn = 1;
    s_tog.delete(); d_tog.delete();
    repeat (15) @(negedge clk);
    check("no_toggle_after_reset", s_tog.size() + d_tog.size(), 0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int blk = 0; blk < 5; blk++) begin
      do_reset();
      p = $urandom_range(1, 8);
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if ($urandom_range(0, p) == 0) sin = ~sin;
        if ($urandom_range(0, p) == 0) din = ~din;
        weight_valid = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 2) != 0) weight_in = NW'(1) << $urandom_range(0, NW - 1);
        else weight_in = NW'($urandom);
      end
      weight_valid = 0;
    end

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
